// File: rtl/ccg_sig_eval.sv
// ---------------------------------------------------------------------------
// ccg_sig_eval
//
// Sequential evaluation harness for generated combinational (or pipelined)
// benchmark circuits. On an accepted start it walks cut_in through every one
// of the 2^N_IN input vectors in ascending order. The CUT response is folded
// into a multiple-input signature register (MISR) in the cycles where the
// CUT output corresponds to an applied vector. At the end of the run the
// signature is compared against a golden value.
//
// CUT latency is covered by delaying a "vector applied" flag through a
// CUT_LAT-deep shift register. Captures therefore line up with the CUT
// output regardless of how many register stages the CUT contains.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       run request, honoured only in IDLE or DONE
//   golden     in   SIG_W   expected signature, sampled as DONE is entered
//   cut_in     out  N_IN    vector driven to the CUT
//   cut_out    in   N_OUT   CUT response
//   busy       out  1       high while vectors are applied or the CUT drains
//   done       out  1       one-cycle pulse on entering DONE
//   pass       out  1       signature matched golden, held until next start
//   signature  out  SIG_W   live MISR contents
// ---------------------------------------------------------------------------
module ccg_sig_eval #(
  parameter int               N_IN    = 2,
  parameter int               N_OUT   = 8,
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(16'h1021),
  parameter int               CUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] golden,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  // The counter is one bit wider than the vector so that the terminal value
  // 2^N_IN-1 is an exact compare with the top bit clear; it never wraps
  // back onto vector 0.
  localparam int            CNT_W      = N_IN + 1;
  localparam logic [CNT_W-1:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};
  // DRAIN lasts CUT_LAT cycles: the down-counter is loaded with CUT_LAT-1
  // and DONE is entered on the cycle it reads zero.
  localparam logic [2:0]    DRAIN_INIT = 3'(CUT_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         drain_q;
  logic [SIG_W-1:0]   sig_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;

  logic               start_ok;
  logic               apply_valid;
  logic               cap_valid;
  logic [SIG_W-1:0]   misr_step;
  logic [SIG_W-1:0]   sig_d;

  // -------------------------------------------------------------------------
  // Capture alignment: a flag raised for every applied vector, delayed by the
  // CUT latency so it marks the cycle in which the matching response appears.
  // -------------------------------------------------------------------------
  assign apply_valid = (state_q == S_APPLY);

  if (CUT_LAT == 0) begin : g_no_pipe
    assign cap_valid = apply_valid;
  end else begin : g_valid_pipe
    logic [CUT_LAT-1:0] vpipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q <= (vpipe_q << 1) | CUT_LAT'(apply_valid);
      end
    end

    assign cap_valid = vpipe_q[CUT_LAT-1];
  end

  // -------------------------------------------------------------------------
  // MISR next value: shift left, apply feedback taps when the MSB falls off,
  // then XOR in the zero-extended CUT response.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a value on every path (the
    // defaults come first), so no latch can be inferred.
    misr_step = {sig_q[SIG_W-2:0], 1'b0};
    sig_d     = sig_q;
    if (sig_q[SIG_W-1]) begin
      misr_step = misr_step ^ POLY;
    end
    misr_step = misr_step ^ SIG_W'(cut_out);
    if (cap_valid) begin
      sig_d = misr_step;
    end
  end

  // A start is only honoured when no run is in flight.
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (start_ok) begin
        // A new run wipes the counter, signature and previous verdict.
        state_q <= S_APPLY;
        cnt_q   <= '0;
        sig_q   <= '0;
        busy_q  <= 1'b1;
        pass_q  <= 1'b0;
      end else begin
        sig_q <= sig_d;

        case (state_q)
          S_APPLY: begin
            if (cnt_q == LAST_VEC) begin
              // cut_in stays on the last vector from here until the next run.
              if (CUT_LAT == 0) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (sig_d == golden);
              end else begin
                state_q <= S_DRAIN;
                drain_q <= DRAIN_INIT;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          S_DRAIN: begin
            // The final response is captured on the same edge DONE is entered.
            if (drain_q == 3'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == golden);
            end else begin
              drain_q <= drain_q - 3'd1;
            end
          end

          default: begin
            // IDLE and DONE hold until an accepted start.
          end
        endcase
      end
    end
  end

  assign cut_in    = cnt_q[N_IN-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_ccg_sig_eval.sv
// ---------------------------------------------------------------------------
// tb_ccg_sig_eval
//
// Directed bench for ccg_sig_eval. Three instances are used:
//   dut0  defaults, CUT is either {6'b0,cut_in} or a constant 8'h01
//   dut1  CUT_LAT=2, CUT is {6'b0,cut_in} behind two register stages
//   dut5  N_IN=5, CUT tied to 8'h01
// Inputs change on the falling edge; outputs are read on the falling edge.
// Cycle numbering: the start is sampled at edge k, and cycle k+n is the
// n-th falling-edge sample after that edge (cycle k+1 is the first).
// ---------------------------------------------------------------------------
module tb_ccg_sig_eval;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // dut0
  logic        start0    = 1'b0;
  logic [15:0] golden0   = 16'h0000;
  logic        sel_const = 1'b0;
  logic [1:0]  cut_in0;
  logic [7:0]  cut_out0;
  logic        busy0, done0, pass0;
  logic [15:0] sig0;

  // dut1
  logic        start1  = 1'b0;
  logic [15:0] golden1 = 16'h0000;
  logic [1:0]  cut_in1;
  logic [7:0]  r1 = 8'h00;
  logic [7:0]  r2 = 8'h00;
  logic        busy1, done1, pass1;
  logic [15:0] sig1;

  // dut5
  logic        start5  = 1'b0;
  logic [15:0] golden5 = 16'h0000;
  logic [4:0]  cut_in5;
  logic        busy5, done5, pass5;
  logic [15:0] sig5;

  logic [15:0] exp_t1 [4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0003};

  always #5 clk = ~clk;

  assign cut_out0 = sel_const ? 8'h01 : {6'b0, cut_in0};

  always @(posedge clk) begin
    r1 <= {6'b0, cut_in1};
    r2 <= r1;
  end

  ccg_sig_eval dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .golden(golden0),
    .cut_in(cut_in0), .cut_out(cut_out0), .busy(busy0), .done(done0),
    .pass(pass0), .signature(sig0)
  );

  ccg_sig_eval #(.CUT_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .golden(golden1),
    .cut_in(cut_in1), .cut_out(r2), .busy(busy1), .done(done1),
    .pass(pass1), .signature(sig1)
  );

  ccg_sig_eval #(.N_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .golden(golden5),
    .cut_in(cut_in5), .cut_out(8'h01), .busy(busy5), .done(done5),
    .pass(pass5), .signature(sig5)
  );

  // -------------------------------------------------------------------------
  task automatic test_reset();
    #1;
    n_cmp++; if ({busy0, done0, pass0} !== 3'b000 || sig0 !== 16'h0 || cut_in0 !== 2'd0) begin
      n_bad++; $display("FAIL reset_dut0 busy/done/pass=%b sig=%h cut_in=%h want 000/0000/0", {busy0, done0, pass0}, sig0, cut_in0);
    end
    n_cmp++; if ({busy1, done1, pass1} !== 3'b000 || sig1 !== 16'h0 || cut_in1 !== 2'd0) begin
      n_bad++; $display("FAIL reset_dut1 busy/done/pass=%b sig=%h cut_in=%h want 000/0000/0", {busy1, done1, pass1}, sig1, cut_in1);
    end
    n_cmp++; if ({busy5, done5, pass5} !== 3'b000 || sig5 !== 16'h0 || cut_in5 !== 5'd0) begin
      n_bad++; $display("FAIL reset_dut5 busy/done/pass=%b sig=%h cut_in=%h want 000/0000/0", {busy5, done5, pass5}, sig5, cut_in5);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0 || cut_in0 !== 2'd0) begin
      n_bad++; $display("FAIL idle_after_reset busy=%b cut_in=%h want 0/0", busy0, cut_in0);
    end
  endtask

  // Full T1-style run on dut0; optionally pulses start again in cycle 2.
  task automatic run_t1(input string name, input bit poke);
    golden0   = 16'h0003;
    sel_const = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n_cmp++; if (busy0 !== 1'b1 || sig0 !== 16'h0 || cut_in0 !== 2'd0 || done0 !== 1'b0) begin
      n_bad++; $display("FAIL %s_c1 busy=%b sig=%h cut_in=%h done=%b want 1/0000/0/0", name, busy0, sig0, cut_in0, done0);
    end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (poke && c == 2) start0 = 1'b1;
      if (poke && c == 3) start0 = 1'b0;
      n_cmp++; if (sig0 !== exp_t1[c-2]) begin
        n_bad++; $display("FAIL %s_sig_c%0d got %h want %h", name, c, sig0, exp_t1[c-2]);
      end
      n_cmp++; if (done0 !== (c == 5) || busy0 !== (c != 5)) begin
        n_bad++; $display("FAIL %s_ctl_c%0d done=%b busy=%b want %b/%b", name, c, done0, busy0, c == 5, c != 5);
      end
      n_cmp++; if (cut_in0 !== ((c == 5) ? 2'd3 : 2'(c - 1))) begin
        n_bad++; $display("FAIL %s_cut_in_c%0d got %h", name, c, cut_in0);
      end
    end
    n_cmp++; if (pass0 !== 1'b1) begin
      n_bad++; $display("FAIL %s_pass got %b want 1", name, pass0);
    end
    @(negedge clk);
    n_cmp++; if (done0 !== 1'b0 || pass0 !== 1'b1 || sig0 !== 16'h0003 || cut_in0 !== 2'd3) begin
      n_bad++; $display("FAIL %s_hold done=%b pass=%b sig=%h cut_in=%h want 0/1/0003/3", name, done0, pass0, sig0, cut_in0);
    end
  endtask

  task automatic test_exhaustive();
    run_t1("t1", 1'b0);
  endtask

  task automatic test_cut_latency();
    int seen = 0;
    logic busy_at = 1'b1;
    golden1 = 16'h0003;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (done1 === 1'b1 && seen == 0) begin
        seen    = c;
        busy_at = busy1;
      end
    end
    n_cmp++; if (seen != 7 || busy_at !== 1'b0) begin
      n_bad++; $display("FAIL t2_done_cycle got %0d busy=%b want 7/0", seen, busy_at);
    end
    n_cmp++; if (sig1 !== 16'h0003 || pass1 !== 1'b1 || cut_in1 !== 2'd3) begin
      n_bad++; $display("FAIL t2_result sig=%h pass=%b cut_in=%h want 0003/1/3", sig1, pass1, cut_in1);
    end
  endtask

  task automatic test_const_cut();
    int seen = 0;
    sel_const = 1'b1;
    golden0   = 16'h0003;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (done0 === 1'b1 && seen == 0) seen = c;
    end
    n_cmp++; if (seen != 5) begin
      n_bad++; $display("FAIL t3_done_cycle got %0d want 5", seen);
    end
    n_cmp++; if (sig0 !== 16'h000F || pass0 !== 1'b0) begin
      n_bad++; $display("FAIL t3_result sig=%h pass=%b want 000F/0", sig0, pass0);
    end
    sel_const = 1'b0;
  endtask

  task automatic test_feedback();
    int seen = 0;
    @(negedge clk); start5 = 1'b1;
    @(negedge clk); start5 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 17) begin
        n_cmp++; if (sig5 !== 16'hFFFF) begin
          n_bad++; $display("FAIL t4_sig_16caps got %h want FFFF", sig5);
        end
      end
      if (c == 18) begin
        n_cmp++; if (sig5 !== 16'hEFDE) begin
          n_bad++; $display("FAIL t4_sig_17caps got %h want EFDE", sig5);
        end
      end
      if (done5 === 1'b1 && seen == 0) seen = c;
    end
    n_cmp++; if (seen != 33 || busy5 !== 1'b0 || cut_in5 !== 5'd31) begin
      n_bad++; $display("FAIL t4_done got cycle %0d busy=%b cut_in=%0d want 33/0/31", seen, busy5, cut_in5);
    end
  endtask

  task automatic test_busy_start();
    run_t1("t5", 1'b1);
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    golden0 = 16'h0003;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (done0 === 1'b1) seen = c;
    end
    n_cmp++; if (seen != 5) begin
      n_bad++; $display("FAIL b2b_first_done got %0d want 5", seen);
    end
    start0 = 1'b1;  // coincident with the done pulse
    @(negedge clk); start0 = 1'b0;
    n_cmp++; if (busy0 !== 1'b1 || done0 !== 1'b0 || sig0 !== 16'h0 || cut_in0 !== 2'd0) begin
      n_bad++; $display("FAIL b2b_restart busy=%b done=%b sig=%h cut_in=%h want 1/0/0000/0", busy0, done0, sig0, cut_in0);
    end
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (done0 === 1'b1) seen = c;
    end
    n_cmp++; if (seen != 5 || sig0 !== 16'h0003 || pass0 !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second got cycle %0d sig=%h pass=%b want 5/0003/1", seen, sig0, pass0);
    end
  endtask

  task automatic test_reset_midrun();
    int dones = 0;
    golden0 = 16'h0003;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (2) @(negedge clk);  // now in cycle 3
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy0 !== 1'b0 || sig0 !== 16'h0 || cut_in0 !== 2'd0 || done0 !== 1'b0 || pass0 !== 1'b0) begin
      n_bad++; $display("FAIL t6_async busy=%b sig=%h cut_in=%h done=%b pass=%b want all 0", busy0, sig0, cut_in0, done0, pass0);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done0 !== 1'b0) dones++;
    end
    n_cmp++; if (dones != 0) begin
      n_bad++; $display("FAIL t6_no_done got %0d done cycles want 0", dones);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_t1("t6_restart", 1'b0);
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_cut_latency();
    test_const_cut();
    test_feedback();
    test_busy_start();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
